// File: rtl/uart_tx_sched.sv
// uart_tx_sched: frame-level scheduler sharing one UART TX byte interface between a command and a work source.
// Ports: clk/rst_n (async active-low); i_enable gates new grants; i_baud_tick paces the inter-frame gap;
// i_gap_cfg idle bit periods after each frame; i_cmd_*/i_work_* valid/ready byte streams with last markers;
// o_tx_* byte stream to the serializer; o_grant one-hot {work,cmd}; o_busy in XFER/GAP; o_frame_done pulse.
module uart_tx_sched #(
  parameter int GAP_W     = 8,
  parameter int CMD_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_enable,
  input  logic             i_baud_tick,
  input  logic [GAP_W-1:0] i_gap_cfg,
  input  logic [7:0]       i_cmd_data,
  input  logic             i_cmd_last,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [7:0]       i_work_data,
  input  logic             i_work_last,
  input  logic             i_work_valid,
  output logic             o_work_ready,
  output logic [7:0]       o_tx_data,
  output logic             o_tx_valid,
  input  logic             i_tx_ready,
  output logic [1:0]       o_grant,
  output logic             o_busy,
  output logic             o_frame_done
);
  localparam int BW = $clog2(CMD_BURST + 1);
  typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;
  state_t           r_state;
  logic [1:0]       r_grant;
  logic [BW-1:0]    r_burst;
  logic [GAP_W-1:0] r_gap;
  logic             r_done;
  logic             w_xfer, w_work_sel, w_last, w_hs_last, w_work_win, w_burst_full;
  assign w_xfer       = r_state == XFER;
  assign w_work_sel   = r_grant[1];
  assign w_last       = w_work_sel ? i_work_last : i_cmd_last;
  assign o_tx_data    = w_work_sel ? i_work_data : i_cmd_data;
  assign o_tx_valid   = w_xfer & (w_work_sel ? i_work_valid : i_cmd_valid);
  assign o_cmd_ready  = w_xfer & r_grant[0] & i_tx_ready;
  assign o_work_ready = w_xfer & r_grant[1] & i_tx_ready;
  assign w_hs_last    = o_tx_valid & i_tx_ready & w_last;
  assign w_burst_full = r_burst == BW'(CMD_BURST);
  // work takes the grant when cmd is absent or cmd has used up its burst allowance
  assign w_work_win   = i_work_valid & (w_burst_full | ~i_cmd_valid);
  assign o_grant      = r_grant;
  assign o_busy       = r_state != IDLE;
  assign o_frame_done = r_done;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_grant <= 2'b00;
      r_burst <= '0;
      r_gap   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (i_enable && (i_cmd_valid || i_work_valid)) begin
          r_state <= XFER;
          if (w_work_win) begin
            r_grant <= 2'b10;
            r_burst <= '0;
          end else begin
            r_grant <= 2'b01;
            r_burst <= !i_work_valid ? '0 : w_burst_full ? r_burst : r_burst + 1'b1;
          end
        end
        XFER: if (w_hs_last) begin
          r_done  <= 1'b1;
          r_grant <= 2'b00;
          r_gap   <= i_gap_cfg;
          r_state <= (i_gap_cfg == '0) ? IDLE : GAP;
        end
        GAP: if (i_baud_tick) begin
          r_gap <= r_gap - 1'b1;
          if (r_gap == GAP_W'(1)) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed self-checking bench for uart_tx_sched.
module tb_uart_tx_sched;
  logic       clk = 1'b0;
  logic       rst_n, enable, baud_tick, cmd_last, cmd_valid, cmd_ready;
  logic       work_last, work_valid, work_ready, tx_valid, tx_ready, busy, frame_done;
  logic [7:0] gap_cfg, cmd_data, work_data, tx_data;
  logic [1:0] grant;
  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] bytes1 [3] = '{8'h55, 8'hAA, 8'h01};

  uart_tx_sched #(.GAP_W(8), .CMD_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n), .i_enable(enable), .i_baud_tick(baud_tick), .i_gap_cfg(gap_cfg),
    .i_cmd_data(cmd_data), .i_cmd_last(cmd_last), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_work_data(work_data), .i_work_last(work_last), .i_work_valid(work_valid), .o_work_ready(work_ready),
    .o_tx_data(tx_data), .o_tx_valid(tx_valid), .i_tx_ready(tx_ready),
    .o_grant(grant), .o_busy(busy), .o_frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 0; enable = 1; baud_tick = 0; gap_cfg = 0; tx_ready = 1;
    cmd_data = 0; cmd_last = 0; cmd_valid = 0; work_data = 0; work_last = 0; work_valid = 0;
    #12;
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_readies", {cmd_ready, work_ready}, 0);
    cyc();
    rst_n = 1;
    cyc();
    // single 3-byte cmd frame
    cmd_valid = 1; cmd_data = bytes1[0];
    #1;
    chk("t1_idle_ready", cmd_ready, 0);
    chk("t1_idle_valid", tx_valid, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      cmd_data = bytes1[i]; cmd_last = (i == 2);
      #1;
      chk("t1_grant", grant, 2'b01);
      chk("t1_data", tx_data, bytes1[i]);
      chk("t1_ready", {tx_valid, cmd_ready, busy}, 3'b111);
    end
    cyc();
    cmd_valid = 0; cmd_last = 0;
    #1;
    chk("t1_end_grant", grant, 0);
    chk("t1_done", frame_done, 1);
    chk("t1_busy", busy, 0);
    cyc();
    chk("t1_done_pulse", frame_done, 0);
    // both sources continuously valid, 1-byte frames
    cmd_valid = 1; cmd_last = 1; cmd_data = 8'hC0;
    work_valid = 1; work_last = 1; work_data = 8'hB0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("t2_grant", grant, (i % 5 == 4) ? 2'b10 : 2'b01);
      chk("t2_data", tx_data, (i % 5 == 4) ? 8'hB0 : 8'hC0);
      cyc();
      chk("t2_idle", grant, 0);
    end
    work_valid = 0;
    // gap of 3 bit periods, cmd kept pending
    gap_cfg = 3;
    cyc();
    chk("t3_grant", grant, 2'b01);
    cyc();
    chk("t3_gap_busy", busy, 1);
    chk("t3_gap_grant", grant, 0);
    chk("t3_gap_valid", {tx_valid, cmd_ready}, 0);
    for (int k = 1; k <= 3; k++) begin
      repeat (31) cyc();
      gap_cfg = 0;
      chk("t3_gap_hold", {busy, grant}, 3'b100);
      baud_tick = 1;
      cyc();
      baud_tick = 0;
      gap_cfg = 3;
    end
    gap_cfg = 0;
    #1;
    chk("t3_after_gap", {busy, grant}, 3'b000);
    cyc();
    chk("t3_regrant", grant, 2'b01);
    cyc();
    cmd_valid = 0;
    #1;
    chk("t3_nogap", {busy, frame_done}, 2'b01);
    // work frame with tx_ready stalls, bubble, and cmd arriving mid-frame
    work_valid = 1; work_last = 0; work_data = 8'hD0;
    cyc();
    tx_ready = 0; cmd_valid = 1; cmd_last = 1;
    #1;
    chk("t4_grant", grant, 2'b10);
    chk("t4_stall", {tx_valid, work_ready, cmd_ready}, 3'b100);
    cyc();
    tx_ready = 1;
    #1;
    chk("t4_wready", {work_ready, cmd_ready}, 2'b10);
    chk("t4_data0", tx_data, 8'hD0);
    cyc();
    work_data = 8'hD1;
    cyc();
    work_valid = 0;
    #1;
    chk("t4_bubble", {tx_valid, grant}, 3'b010);
    cyc();
    work_valid = 1; work_data = 8'hD2; tx_ready = 0;
    cyc();
    tx_ready = 1;
    cyc();
    work_data = 8'hD3; work_last = 1;
    #1;
    chk("t4_last", {grant, cmd_ready, tx_data}, {2'b10, 1'b0, 8'hD3});
    cyc();
    work_valid = 0;
    #1;
    chk("t4_done", {grant, frame_done}, 3'b001);
    cyc();
    chk("t4_cmd_grant", grant, 2'b01);
    cyc();
    cmd_valid = 0;
    // reset mid-frame on byte 2 of 5
    cmd_valid = 1; cmd_last = 0; work_valid = 1; work_last = 1;
    cyc();
    chk("t5_grant", grant, 2'b01);
    cyc();
    rst_n = 0;
    #1;
    chk("t5_rst", {grant, busy, tx_valid, cmd_ready, work_ready, frame_done}, 0);
    cyc();
    rst_n = 1; cmd_last = 1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("t5_seq", grant, (i == 4) ? 2'b10 : 2'b01);
      cyc();
    end
    // enable gating
    enable = 0;
    repeat (3) cyc();
    chk("t6_hold", {grant, busy}, 0);
    enable = 1; cmd_last = 0;
    cyc();
    enable = 0;
    #1;
    chk("t6_grant", grant, 2'b01);
    cyc();
    cmd_last = 1;
    #1;
    chk("t6_keep", grant, 2'b01);
    cyc();
    chk("t6_done", {grant, frame_done}, 3'b001);
    cyc();
    cyc();
    chk("t6_blocked", {grant, busy}, 0);
    enable = 1;
    cyc();
    chk("t6_resume", grant, 2'b01);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
